// File: rtl/fx2_pkg.sv
// rtl/fx2_pkg.sv - shared FX2LP slave-FIFO types and constants
//
// Purpose: packet FSM state encoding, FIFOADR endpoint selects and the
//          default EP6 packet size shared by the slave-FIFO front end.
// Ports:   none (package).

package fx2_pkg;

    typedef enum logic [1:0] {
        P_IDLE   = 2'd0,
        P_FILL   = 2'd1,
        P_COMMIT = 2'd2
    } pkt_state_t;

    // FIFOADR[1:0] endpoint selects
    localparam logic [1:0] FIFOADR_EP2 = 2'b00;
    localparam logic [1:0] FIFOADR_EP4 = 2'b01;
    localparam logic [1:0] FIFOADR_EP6 = 2'b10;
    localparam logic [1:0] FIFOADR_EP8 = 2'b11;

    localparam int EP6_PKT_BYTES = 512;

endpackage

// File: rtl/sync_fifo_sa.sv
// rtl/sync_fifo_sa.sv - parameterised show-ahead synchronous FIFO
//
// Purpose: single-clock FIFO whose head entry is always visible on rdata.
//          A push into a full FIFO is accepted only when a pop happens in
//          the same cycle; otherwise it is ignored (the caller flags it).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push, wdata  write request and data
//   pop          read request (caller only pops when not empty)
//   rdata        head entry, zero while empty
//   full, empty  occupancy flags derived from the registered level
//   level        registered occupancy, 0..DEPTH

module sync_fifo_sa #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic w_wr_en;
    logic w_rd_en;

    assign empty   = (r_level == '0);
    assign full    = (r_level == LVL_FULL);
    assign w_rd_en = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_wr_en = push && (!full || w_rd_en);

    assign level = r_level;
    assign rdata = empty ? '0 : r_mem[r_rd_ptr];

    // Storage is not reset; the level gates what is visible.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/stream_in_packer.sv
// rtl/stream_in_packer.sv - 2-bit sample packer feeding the EP6 slave-FIFO writer
//
// Purpose: packs four 2-bit samples LSB-first into a byte, buffers bytes in
//          a show-ahead FIFO, and tracks the USB packet so that a partial
//          packet which has gone idle is committed with a PKTEND request.
// Ports:
//   clk, rst_n              clock (also IFCLK), synchronous active-low reset
//   sample_in, sample_valid 2-bit sample stream, no backpressure
//   byte_out, byte_valid    FIFO head byte towards the slave-FIFO writer
//   byte_ready              writer accepts byte_out this cycle
//   pkt_end_req             one-cycle request to commit a short packet
//   overflow                sticky: a packed byte was dropped
//   fifo_level              registered FIFO occupancy

module stream_in_packer
    import fx2_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int PKT_BYTES    = EP6_PKT_BYTES,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    sample_in,
    input  logic                          sample_valid,
    output logic [7:0]                    byte_out,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic                          pkt_end_req,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = $clog2(PKT_BYTES);
    localparam int TW = $clog2(IDLE_TIMEOUT);
    localparam logic [CW-1:0] PKT_LAST = CW'(PKT_BYTES - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(IDLE_TIMEOUT - 1);

    // Packing state
    logic [5:0]   r_shift;
    logic [1:0]   r_scnt;

    // Packet tracking state
    pkt_state_t   r_state;
    logic [CW-1:0] r_pkt_cnt;
    logic [TW-1:0] r_timer;

    logic         w_push;
    logic [7:0]   w_push_byte;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic         w_drop;
    logic [7:0]   w_head;

    // ------------------------------------------------------------------
    // Packer: the 4th sample completes the byte and is pushed on the same
    // edge straight from the input, so it never lands in r_shift.
    // ------------------------------------------------------------------
    assign w_push      = sample_valid && (r_scnt == 2'd3);
    assign w_push_byte = {sample_in, r_shift};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_scnt  <= '0;
        end else if (sample_valid) begin
            if (r_scnt != 2'd3) begin
                r_shift[{r_scnt, 1'b0} +: 2] <= sample_in;
            end
            r_scnt <= r_scnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Byte buffer
    // ------------------------------------------------------------------
    sync_fifo_sa #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_push_byte),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // byte_valid depends only on registered FIFO level and FSM state.
    // It is held low during P_COMMIT so no byte can slip in ahead of PKTEND.
    assign byte_valid = !w_empty && (r_state != P_COMMIT);
    assign byte_out   = w_head;
    assign w_pop      = byte_valid && byte_ready;
    assign w_drop     = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (w_drop) begin
            overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM: counts popped bytes; full packets auto-commit in the
    // FX2LP, idle partial packets get a PKTEND once the FIFO has drained.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= P_IDLE;
            r_pkt_cnt   <= '0;
            r_timer     <= '0;
            pkt_end_req <= 1'b0;
        end else begin
            pkt_end_req <= 1'b0;
            unique case (r_state)
                P_IDLE: begin
                    r_timer <= '0;
                    if (w_pop) begin
                        r_state   <= P_FILL;
                        r_pkt_cnt <= CW'(1);
                    end
                end
                P_FILL: begin
                    if (w_pop) begin
                        r_timer <= '0;
                        if (r_pkt_cnt == PKT_LAST) begin
                            r_pkt_cnt <= '0;
                            r_state   <= P_IDLE;
                        end else begin
                            r_pkt_cnt <= r_pkt_cnt + 1'b1;
                        end
                    end else if (r_timer == TMR_LAST) begin
                        // Timer saturates here while data is still queued.
                        if (w_empty) begin
                            r_state     <= P_COMMIT;
                            pkt_end_req <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                P_COMMIT: begin
                    r_state   <= P_IDLE;
                    r_pkt_cnt <= '0;
                    r_timer   <= '0;
                end
                default: begin
                    r_state   <= P_IDLE;
                    r_pkt_cnt <= '0;
                    r_timer   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_in_packer.sv
// tb/tb_stream_in_packer.sv - directed self-checking bench for stream_in_packer

module tb_stream_in_packer;
    import fx2_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] sample_in;
    logic       sample_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       pkt_end_req;
    logic       overflow;
    logic [4:0] fifo_level;

    int n_tests = 0;
    int n_fail  = 0;
    int pe_cnt  = 0;
    int pe_bad  = 0;
    logic [7:0] popq [$];

    stream_in_packer #(
        .FIFO_DEPTH   (16),
        .PKT_BYTES    (512),
        .IDLE_TIMEOUT (1024)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .pkt_end_req  (pkt_end_req),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after posedge, so negedge sees what posedge will use.
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid && byte_ready) popq.push_back(byte_out);
            if (pkt_end_req) begin
                pe_cnt++;
                if (byte_valid) pe_bad++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        sample_in    = 2'd0;
        rst_n        = 1'b0;
        step();
        rst_n        = 1'b1;
        popq.delete();
        pe_cnt = 0;
        pe_bad = 0;
    endtask

    task automatic send_sample(input logic [1:0] s);
        sample_valid = 1'b1;
        sample_in    = s;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) send_sample(b[2*i +: 2]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  32'(byte_valid),  32'd0);
        check({tag, "_out"},    32'(byte_out),    32'd0);
        check({tag, "_level"},  32'(fifo_level),  32'd0);
        check({tag, "_ovf"},    32'(overflow),    32'd0);
        check({tag, "_pkend"},  32'(pkt_end_req), 32'd0);
    endtask

    logic [7:0] exp_q [$];
    int k_pulse;

    initial begin
        rst_n        = 1'b0;
        byte_ready   = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 2'd0;
        step();
        do_reset();
        check_reset_outputs("rst");
        check("rst_state", 32'(dut.r_state), 32'(P_IDLE));

        // T1: samples 1,2,3,0 -> 0x39, valid for one cycle
        byte_ready = 1'b1;
        send_sample(2'd1);
        send_sample(2'd2);
        send_sample(2'd3);
        check("t1_not_early", 32'(byte_valid), 32'd0);
        send_sample(2'd0);
        check("t1_valid", 32'(byte_valid), 32'd1);
        check("t1_byte",  32'(byte_out),   32'h39);
        step();
        check("t1_valid_gone", 32'(byte_valid), 32'd0);
        check("t1_ovf",        32'(overflow),   32'd0);

        // T2: overflow on the 17th push, first 16 drain in order
        do_reset();
        byte_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        check("t2_level16", 32'(fifo_level), 32'd16);
        check("t2_no_ovf",  32'(overflow),   32'd0);
        send_byte(8'hEE);
        check("t2_level_full", 32'(fifo_level), 32'd16);
        check("t2_ovf",        32'(overflow),   32'd1);
        byte_ready = 1'b1;
        repeat (20) step();
        check("t2_drain_cnt", 32'(popq.size()), 32'd16);
        for (int i = 0; i < 16 && i < popq.size(); i++)
            check("t2_drain_byte", 32'(popq[i]), 32'h10 + 32'(i));
        check("t2_ovf_sticky", 32'(overflow), 32'd1);

        // T3: push and pop together while full
        do_reset();
        byte_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h40 + 8'(i));
            exp_q.push_back(8'h40 + 8'(i));
        end
        exp_q.push_back(8'hA5);
        send_sample(2'b01);
        send_sample(2'b01);
        send_sample(2'b10);
        byte_ready = 1'b1;
        send_sample(2'b10);
        byte_ready = 1'b0;
        check("t3_level", 32'(fifo_level), 32'd16);
        check("t3_ovf",   32'(overflow),   32'd0);
        byte_ready = 1'b1;
        repeat (20) step();
        check("t3_drain_cnt", 32'(popq.size()), 32'd17);
        for (int i = 0; i < 17 && i < popq.size(); i++)
            check("t3_order", 32'(popq[i]), 32'(exp_q[i]));

        // T4: full 512-byte packet, no PKTEND
        do_reset();
        byte_ready = 1'b1;
        for (int i = 0; i < 512; i++) send_byte(8'(i));
        step();
        step();
        check("t4_pops",    32'(popq.size()),    32'd512);
        check("t4_first",   32'(popq[0]),        32'h00);
        check("t4_last",    32'(popq[511]),      32'hFF);
        check("t4_no_pkend", 32'(pe_cnt),        32'd0);
        check("t4_state",   32'(dut.r_state),    32'(P_IDLE));
        check("t4_pkt_cnt", 32'(dut.r_pkt_cnt),  32'd0);

        // T5: short packet times out -> single PKTEND
        do_reset();
        byte_ready = 1'b1;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        k_pulse = -1;
        for (int k = 1; k <= 1200; k++) begin
            step();
            if (pkt_end_req && k_pulse < 0) k_pulse = k;
        end
        check("t5_pulse_seen", 32'(k_pulse >= 0), 32'd1);
        check("t5_pulse_time", 32'(k_pulse),      32'd1025);
        check("t5_pulse_cnt",  32'(pe_cnt),       32'd1);
        check("t5_valid_low",  32'(pe_bad),       32'd0);
        check("t5_pkt_cnt0",   32'(dut.r_pkt_cnt), 32'd0);
        check("t5_state_idle", 32'(dut.r_state),  32'(P_IDLE));
        send_byte(8'h77);
        step();
        check("t5_new_pkt_cnt", 32'(dut.r_pkt_cnt), 32'd1);
        check("t5_new_state",   32'(dut.r_state),   32'(P_FILL));

        // T6: reset mid-packet discards buffered and partial data
        do_reset();
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
        send_sample(2'd2);
        send_sample(2'd1);
        check("t6_level_pre", 32'(fifo_level), 32'd5);
        do_reset();
        check_reset_outputs("t6");
        byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_sample(2'd3);
        repeat (10) step();
        check("t6_one_byte", 32'(popq.size()), 32'd1);
        if (popq.size() > 0) check("t6_byte", 32'(popq[0]), 32'hFF);
        check("t6_no_pkend", 32'(pe_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_in_packer.md
Name: stream_in_packer

Overview:
- Upstream feeder for the EP6 slave-FIFO write stage.
- Collects 2-bit samples from the acquisition front end and packs four samples into each byte.
- Buffers bytes in a small show-ahead FIFO and presents them on a valid/ready byte interface to the slave-FIFO writer.
- Requests a short-packet commit (PKTEND) when a partial USB packet has gone idle.

Parameters:
- FIFO_DEPTH, 16, byte buffer depth; power of two, at least 4.
- PKT_BYTES, 512, EP6 packet size in bytes; when the popped-byte count reaches this value, the packet auto-commits.
- IDLE_TIMEOUT, 1024, idle cycles before a partial packet is committed.

Ports:
- clk  in  1  single system clock (same clock driven to the FX2LP IFCLK).
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- sample_in  in  2  sample data.
- sample_valid  in  1  sample_in is valid this cycle; no backpressure to the source.
- byte_out  out  8  FIFO head byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  downstream accepts byte_out this cycle; high while EP6 is not full.
- pkt_end_req  out  1  one-cycle pulse: commit the current short packet.
- overflow  out  1  sticky flag: a packed byte was dropped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low at a clk edge):
  - byte_valid=0, pkt_end_req=0, overflow=0, fifo_level=0, byte_out=0.
  - Packing shift register, sample counter, FIFO pointers, packet counter and idle timer all cleared.
  - FSM goes to P_IDLE.
  - Reset mid-packet discards all buffered and partial data; no pkt_end_req is issued.
- Packing:
  - Samples are placed LSB-first: the 1st valid sample goes to bits [1:0], the 4th to bits [7:6].
  - On the 4th valid sample, the completed byte is pushed on the same edge and the sample counter wraps to 0.
  - A partial byte is held indefinitely; it is never flushed by the timeout.
- FIFO:
  - Show-ahead. A byte pushed at edge N gives byte_valid=1 with that byte on byte_out after edge N.
  - Pop occurs when byte_valid && byte_ready.
  - Push while full with a simultaneous pop: the push is accepted and the level is unchanged.
  - Push while full without a pop: the byte is dropped, overflow is set, and it stays set until reset.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level is the registered count and stays in the range 0..FIFO_DEPTH.
- Packet FSM (pkt_cnt counts popped bytes, 0..PKT_BYTES-1):
  - P_IDLE: pkt_cnt==0 and the timer is held at 0. A pop moves the FSM to P_FILL with pkt_cnt=1.
  - P_FILL:
    - Each pop increments pkt_cnt.
    - A pop that brings pkt_cnt to PKT_BYTES wraps pkt_cnt to 0 and returns to P_IDLE, with no pkt_end_req; the FX2LP auto-commits full packets.
    - The idle timer increments on each cycle with no pop and resets to 0 on any pop.
    - When the timer reaches IDLE_TIMEOUT-1 and the FIFO is empty, go to P_COMMIT.
    - If the FIFO is non-empty at that point, the timer saturates and the FSM waits, because data is still pending.
  - P_COMMIT:
    - Lasts exactly one cycle with pkt_end_req=1 and byte_valid forced to 0, so no pop happens in that cycle and ordering versus PKTEND is preserved.
    - Next state is P_IDLE with pkt_cnt=0 and the timer at 0.
    - A push during P_COMMIT is accepted normally; the byte appears on the following cycle.
- Width rules: pkt_cnt is $clog2(PKT_BYTES) bits; the timer is $clog2(IDLE_TIMEOUT) bits. All outputs are registered except byte_out and byte_valid, which are driven from the FIFO registers and the FSM state with no input-to-output combinational path.

Decomposition:
- Shared package fx2_pkg:
  - FSM state encoding (P_IDLE, P_FILL, P_COMMIT).
  - FIFOADR constants (EP2=2'b00, EP4=2'b01, EP6=2'b10, EP8=2'b11).
  - Default EP6 packet size of 512.
- One sub-module, sync_fifo_sa: a parameterised show-ahead synchronous FIFO with push, pop, full, empty and level. The packer and packet FSM stay in the top module.

Test Plan:
- Reset then samples 1,2,3,0 on consecutive cycles with byte_ready=1 -> byte_out=8'h39, byte_valid high for exactly 1 cycle starting the cycle after the 4th sample; overflow=0.
- byte_ready=0, 17 bytes pushed with FIFO_DEPTH=16 -> fifo_level=16, overflow=1 after the 17th push; on draining, the first 16 bytes come out in order and the 17th is absent.
- Full FIFO with push and pop in the same cycle -> fifo_level stays 16, overflow stays 0, the new byte is last in order.
- 512 bytes streamed continuously with byte_ready=1 -> pkt_end_req never asserts; pkt_cnt returns to 0 and FSM is in P_IDLE after the 512th pop.
- 3 bytes popped, then no samples for IDLE_TIMEOUT cycles -> a single pkt_end_req pulse with byte_valid=0 in that cycle; a later byte starts a new packet with pkt_cnt=1.
- rst_n low for 1 cycle after 2 samples and 5 buffered bytes -> all outputs return to reset values; next 4 samples produce exactly one byte with no pkt_end_req.
